alu_issue_decode: RTL and testbench

Decode-and-issue pipeline stage sitting directly in front of the execute-stage ALU. It accepts a RISC-V RV32I instruction with its PC and register operands and produces the ALU's operand pair and 4-bit ALU control code. Each result is held in a two-entry valid/ready output buffer so the execute stage can stall without combinational ready paths back into decode. It flags encodings the ALU cannot service.

---
 rtl/alu_issue_decode.sv | 239 +++++++++++++++++++++++
 tb/tb_alu_issue_decode.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_decode.sv
// RV32I decode-and-issue stage: derives ALU operands/control from an instruction
// and holds results in a two-entry head/skid buffer with a registered in_ready.
module alu_issue_decode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output logic [3:0]  alu_control,
    output logic [4:0]  rd_out,
    output logic [31:0] pc_out,
    output logic        illegal
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_TWO
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_t;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        alu_op_t     ctrl;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        illegal;
    } entry_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic [31:0] shamt;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u  = {instr[31:12], 12'b0};
    assign shamt  = {27'b0, instr[24:20]};

    logic        dec_legal;
    logic [31:0] dec_op1;
    logic [31:0] dec_op2;
    alu_op_t     dec_ctrl;
    entry_t      dec_entry;

    always_comb begin
        dec_legal = 1'b1;
        dec_op1   = rs1_data;
        dec_op2   = rs2_data;
        dec_ctrl  = ALU_ADD;
        case (opcode)
            OPC_OP: begin
                if (!((funct7 == F7_BASE) ||
                      ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)))))
                    dec_legal = 1'b0;
                case (funct3)
                    3'b000:  dec_ctrl = funct7[5] ? ALU_SUB : ALU_ADD;
                    3'b001:  dec_ctrl = ALU_SLL;
                    3'b010:  dec_ctrl = ALU_SLT;
                    3'b011:  dec_ctrl = ALU_SLTU;
                    3'b100:  dec_ctrl = ALU_XOR;
                    3'b101:  dec_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  dec_ctrl = ALU_OR;
                    default: dec_ctrl = ALU_AND;
                endcase
            end
            OPC_OP_IMM: begin
                dec_op2 = imm_i;
                case (funct3)
                    3'b000: dec_ctrl = ALU_ADD;
                    3'b001: begin
                        dec_ctrl  = ALU_SLL;
                        dec_op2   = shamt;
                        dec_legal = (funct7 == F7_BASE);
                    end
                    3'b010: dec_ctrl = ALU_SLT;
                    3'b011: dec_ctrl = ALU_SLTU;
                    3'b100: dec_ctrl = ALU_XOR;
                    3'b101: begin
                        dec_ctrl  = funct7[5] ? ALU_SRA : ALU_SRL;
                        dec_op2   = shamt;
                        dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                    3'b110:  dec_ctrl = ALU_OR;
                    default: dec_ctrl = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                dec_op1 = '0;
                dec_op2 = imm_u;
            end
            OPC_AUIPC: begin
                dec_op1 = pc;
                dec_op2 = imm_u;
            end
            OPC_LOAD:  dec_op2 = imm_i;
            OPC_STORE: dec_op2 = imm_s;
            OPC_BRANCH: begin
                case (funct3[2:1])
                    2'b00:   dec_ctrl = ALU_SUB;
                    2'b10:   dec_ctrl = ALU_SLT;
                    2'b11:   dec_ctrl = ALU_SLTU;
                    default: dec_legal = 1'b0;
                endcase
            end
            OPC_JAL: begin
                dec_op1 = pc;
                dec_op2 = 32'd4;
            end
            OPC_JALR: begin
                dec_op1   = pc;
                dec_op2   = 32'd4;
                dec_legal = (funct3 == 3'b000);
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Unsupported encodings still occupy a slot so ordering is preserved downstream.
    always_comb begin
        dec_entry.op1     = dec_legal ? dec_op1 : '0;
        dec_entry.op2     = dec_legal ? dec_op2 : '0;
        dec_entry.ctrl    = dec_legal ? dec_ctrl : ALU_ADD;
        dec_entry.rd      = instr[11:7];
        dec_entry.pc      = pc;
        dec_entry.illegal = ~dec_legal;
    end

    state_t state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    logic   in_ready_q, in_ready_d;
    logic   accept;
    logic   pop;

    assign accept = in_valid & in_ready_q;
    assign pop    = (state_q != S_EMPTY) & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_d = S_ONE;
                        head_d  = dec_entry;
                    end
                end
                S_ONE: begin
                    if (accept && pop) begin
                        head_d = dec_entry;
                    end else if (accept) begin
                        state_d = S_TWO;
                        skid_d  = dec_entry;
                    end else if (pop) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (pop) begin
                        state_d = S_ONE;
                        head_d  = skid_q;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
        // Ready is registered from the next occupancy so no ready path reaches out_ready.
        in_ready_d = (state_d != S_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != S_EMPTY);
    assign op1         = head_q.op1;
    assign op2         = head_q.op2;
    assign alu_control = head_q.ctrl;
    assign rd_out      = head_q.rd;
    assign pc_out      = head_q.pc;
    assign illegal     = head_q.illegal;

endmodule

// File: tb/tb_alu_issue_decode.sv
// Randomized bench for alu_issue_decode: instruction-semantics reference model
// plus a FIFO scoreboard of expected buffer contents.
module tb_alu_issue_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  alu_control;
    logic [4:0]  rd_out;
    logic [31:0] pc_out;
    logic        illegal;

    alu_issue_decode dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .pc          (pc),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .op1         (op1),
        .op2         (op2),
        .alu_control (alu_control),
        .rd_out      (rd_out),
        .pc_out      (pc_out),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // ALU code per funct3 for the base (non-alternate) operation: ADD SLL SLT SLTU XOR SRL OR AND.
    int r_map [8] = '{0, 5, 8, 9, 4, 6, 3, 2};
    // Branch code per funct3 pair: SUB, (reserved), SLT, SLTU.
    int b_map [4] = '{1, 0, 8, 9};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model_decode(input logic [31:0] i, input logic [31:0] p,
                                          input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [6:0]  f7;
        int          f3;
        int          code;
        logic        ok;
        logic [31:0] iimm;
        logic [31:0] simm;
        f7   = i[31:25];
        f3   = int'(i[14:12]);
        iimm = $signed(i) >>> 20;
        simm = (iimm & ~32'h1F) | {27'b0, i[11:7]};
        ok   = 1'b1;
        code = 0;
        e.op1 = a;
        e.op2 = b;
        e.rd  = i[11:7];
        e.pc  = p;
        case (i[6:0])
            7'h33: begin
                ok   = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                code = r_map[f3] + ((f7 == 7'h20) ? 1 : 0);
            end
            7'h13: begin
                e.op2 = iimm;
                code  = r_map[f3];
                if (f3 == 1) begin
                    e.op2 = {27'b0, i[24:20]};
                    ok    = (f7 == 7'h00);
                end else if (f3 == 5) begin
                    e.op2 = {27'b0, i[24:20]};
                    ok    = (f7 == 7'h00) || (f7 == 7'h20);
                    code  = code + ((f7 == 7'h20) ? 1 : 0);
                end
            end
            7'h37: begin e.op1 = 0; e.op2 = i & 32'hFFFF_F000; end
            7'h17: begin e.op1 = p; e.op2 = i & 32'hFFFF_F000; end
            7'h03: e.op2 = iimm;
            7'h23: e.op2 = simm;
            7'h63: begin
                code = b_map[f3 / 2];
                ok   = (f3 / 2) != 1;
            end
            7'h6F: begin e.op1 = p; e.op2 = 4; end
            7'h67: begin e.op1 = p; e.op2 = 4; ok = (f3 == 0); end
            default: ok = 1'b0;
        endcase
        e.ctrl = 4'(code);
        e.ill  = ~ok;
        if (!ok) begin
            e.op1  = 0;
            e.op2  = 0;
            e.ctrl = 0;
        end
        return e;
    endfunction

    task automatic check_outputs();
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check("in_ready", 32'(in_ready), 32'(q.size() < 2));
        if (q.size() > 0) begin
            check("op1", op1, q[0].op1);
            check("op2", op2, q[0].op2);
            check("alu_control", 32'(alu_control), 32'(q[0].ctrl));
            check("rd_out", 32'(rd_out), 32'(q[0].rd));
            check("pc_out", pc_out, q[0].pc);
            check("illegal", 32'(illegal), 32'(q[0].ill));
        end
    endtask

    // One clock: drive, advance model at the edge, compare on the falling edge.
    task automatic step(input logic v, input logic [31:0] i, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic ordy, input logic fl);
        logic acc;
        logic pp;
        in_valid  = v;
        instr     = i;
        pc        = p;
        rs1_data  = a;
        rs2_data  = b;
        out_ready = ordy;
        flush     = fl;
        acc = v && (q.size() < 2);
        pp  = (q.size() > 0) && ordy;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (pp) q.delete(0);
            if (acc) q.push_back(model_decode(i, p, a, b));
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          sel;
        w   = $urandom;
        sel = $urandom_range(0, 10);
        case (sel)
            0: w[6:0] = 7'h33;
            1: w[6:0] = 7'h13;
            2: w[6:0] = 7'h37;
            3: w[6:0] = 7'h17;
            4: w[6:0] = 7'h03;
            5: w[6:0] = 7'h23;
            6: w[6:0] = 7'h63;
            7: w[6:0] = 7'h6F;
            8: w[6:0] = 7'h67;
            9: w[6:0] = 7'h13;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        if (sel == 8 && $urandom_range(0, 1) == 1) w[14:12] = 3'b000;
        return w;
    endfunction

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        instr     = '0;
        pc        = '0;
        rs1_data  = '0;
        rs2_data  = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_op1", op1, 32'd0);
        check("rst_op2", op2, 32'd0);
        check("rst_ctrl", 32'(alu_control), 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        rst_n = 1'b1;

        step(1'b1, 32'h402081B3, 32'h100, 32'd10, 32'd3, 1'b1, 1'b0);
        check("sub_valid", 32'(out_valid), 32'd1);
        check("sub_op1", op1, 32'd10);
        check("sub_op2", op2, 32'd3);
        check("sub_ctrl", 32'(alu_control), 32'h1);
        check("sub_rd", 32'(rd_out), 32'd3);
        check("sub_illegal", 32'(illegal), 32'd0);

        step(1'b1, 32'h40335293, 32'h104, 32'h80000000, 32'h0, 1'b1, 1'b0);
        check("srai_op2", op2, 32'h3);
        check("srai_ctrl", 32'(alu_control), 32'h7);
        step(1'b1, 32'h00335293, 32'h108, 32'h80000000, 32'h0, 1'b1, 1'b0);
        check("srli_op2", op2, 32'h3);
        check("srli_ctrl", 32'(alu_control), 32'h6);

        step(1'b1, 32'h123450B7, 32'h10C, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0);
        check("lui_op1", op1, 32'h0);
        check("lui_op2", op2, 32'h12345000);
        check("lui_ctrl", 32'(alu_control), 32'h0);
        step(1'b1, 32'h12345097, 32'h40, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0);
        check("auipc_op1", op1, 32'h40);
        check("auipc_op2", op2, 32'h12345000);

        step(1'b1, 32'h0000007F, 32'h44, 32'h11, 32'h22, 1'b1, 1'b0);
        check("illegal_flag", 32'(illegal), 32'd1);
        check("illegal_ctrl", 32'(alu_control), 32'h0);
        step(1'b1, 32'h00006063, 32'h48, 32'd5, 32'd7, 1'b1, 1'b0);
        check("bltu_ctrl", 32'(alu_control), 32'h9);
        check("bltu_op1", op1, 32'd5);
        check("bltu_op2", op2, 32'd7);
        idle(2);

        // Backpressure: two accepted, third held until the drain starts.
        step(1'b1, 32'h00208133, 32'h200, 32'd1, 32'd2, 1'b0, 1'b0);
        step(1'b1, 32'h0020C1B3, 32'h204, 32'd3, 32'd4, 1'b0, 1'b0);
        check("bp_ready_low", 32'(in_ready), 32'd0);
        step(1'b1, 32'h0020F233, 32'h208, 32'd5, 32'd6, 1'b0, 1'b0);
        check("bp_head_pc", pc_out, 32'h200);
        step(1'b1, 32'h0020F233, 32'h208, 32'd5, 32'd6, 1'b1, 1'b0);
        check("bp_second_pc", pc_out, 32'h204);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        step(1'b1, 32'h0020F233, 32'h208, 32'd5, 32'd6, 1'b1, 1'b0);
        check("bp_third_pc", pc_out, 32'h208);
        idle(2);

        // Flush from a full buffer with a valid input present.
        step(1'b1, 32'h00100093, 32'h300, 32'd0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 32'h00200113, 32'h304, 32'd0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 32'h00300193, 32'h308, 32'd0, 32'd0, 1'b1, 1'b1);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_ready", 32'(in_ready), 32'd1);
        idle(3);

        // Asynchronous reset while holding two entries.
        step(1'b1, 32'h00100093, 32'h400, 32'd0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 32'h00200113, 32'h404, 32'd0, 32'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd1);
        check("arst_pc_out", pc_out, 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 9) < 7, rand_instr(), $urandom, $urandom, $urandom,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
